// File: rtl/dispatch_pkg.sv
// Shared constants for the dispatch scoreboard.
// Holds the RV32 opcode values that steer source-register checking, the stage
// indices that select bits of HAZARD_MASK, and helpers that decide which source
// fields of an instruction are real register reads.
package dispatch_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // Bit positions inside HAZARD_MASK.
    localparam int unsigned STAGE_ID   = 0;
    localparam int unsigned STAGE_EXE  = 1;
    localparam int unsigned STAGE_MEM  = 2;
    localparam int unsigned STAGE_WB   = 3;
    localparam int unsigned NUM_STAGES = 4;

    // U-type and JAL carry immediate bits where rs1 would sit.
    function automatic logic uses_rs1(input logic [6:0] opcode);
        return !((opcode == OPC_LUI) || (opcode == OPC_AUIPC) || (opcode == OPC_JAL));
    endfunction

    // Only R-type, stores and branches read a second register.
    function automatic logic uses_rs2(input logic [6:0] opcode);
        return (opcode == OPC_OP) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);
    endfunction

endpackage

// File: rtl/dispatch_scoreboard_if.sv
// Enqueue/dispatch handshake bundle for the dispatch scoreboard.
//   in_valid/in_ready/in_instruction    : producer pushes instructions
//   out_valid/out_ready/out_instruction : consumer takes the queue head
// master drives requests and out_ready; slave (the scoreboard) drives the rest.
interface dispatch_scoreboard_if #(
    parameter int unsigned DATA_WIDTH = 32
) ();
    import dispatch_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_instruction;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_instruction;

    modport master (
        output in_valid,
        output in_instruction,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_instruction
    );

    modport slave (
        input  in_valid,
        input  in_instruction,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_instruction
    );

endinterface

// File: rtl/dispatch_queue_fifo.sv
// Circular instruction queue.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   flush        : empties the queue, overriding push/pop in the same cycle
//   push/wdata   : write when not full
//   pop          : advance head when not empty
//   rdata        : head entry (combinational, don't-care when empty)
//   count        : occupancy; full/empty derived from it
// Storage is never cleared; only pointers and count are reset.
module dispatch_queue_fifo
    import dispatch_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned QUEUE_DEPTH = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         push,
    input  logic                         pop,
    input  logic [DATA_WIDTH-1:0]        wdata,
    output logic [DATA_WIDTH-1:0]        rdata,
    output logic [$clog2(QUEUE_DEPTH):0] count,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem [QUEUE_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  do_push;
    logic                  do_pop;

    assign full  = (count_q == CNT_W'(QUEUE_DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem[rd_ptr_q];

    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Power-of-two depth: pointers wrap by natural overflow.
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push && !reset) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/dispatch_scoreboard.sv
// Dispatch scoreboard: queues instructions and holds the head back while any
// enabled pipeline stage is about to write one of its source registers.
//   clock, reset      : rising-edge clock, synchronous active-high reset
//   report            : status-dump request for simulation monitors; no logic effect
//   flush             : drop every queued instruction (stall_count kept)
//   bus               : enqueue and dispatch handshakes (slave side)
//   <stage>_dest/_wen : destination and write enable of ID/EXE/MEM/WB
//   count             : queue occupancy
//   stall_count       : saturating count of cycles the head was hazard-blocked
module dispatch_scoreboard
    import dispatch_pkg::*;
#(
    parameter int unsigned CORE        = 0,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned INDEX_WIDTH = 8,
    parameter int unsigned QUEUE_DEPTH = 8,
    parameter logic [3:0]  HAZARD_MASK = 4'b1111
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         report,
    input  logic                         flush,
    dispatch_scoreboard_if.slave         bus,
    input  logic [4:0]                   id_dest,
    input  logic [4:0]                   exe_dest,
    input  logic [4:0]                   mem_dest,
    input  logic [4:0]                   wb_dest,
    input  logic                         id_wen,
    input  logic                         exe_wen,
    input  logic                         mem_wen,
    input  logic                         wb_wen,
    output logic                         out_valid_unused_mirror,
    output logic [$clog2(QUEUE_DEPTH):0] count,
    output logic [31:0]                  stall_count
);

    // Kept for interface compatibility with the rest of the core.
    localparam int unsigned unused_core        = CORE;
    localparam int unsigned unused_index_width = INDEX_WIDTH;

    logic [DATA_WIDTH-1:0] head;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic                  hazard;
    logic [6:0]            opcode;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic                  check_rs1;
    logic                  check_rs2;
    logic [NUM_STAGES-1:0]      stage_wen;
    logic [NUM_STAGES-1:0][4:0] stage_dest;
    logic [NUM_STAGES-1:0]      stage_hazard;
    logic [31:0]           stall_q, stall_d;

    dispatch_queue_fifo #(
        .DATA_WIDTH  (DATA_WIDTH),
        .QUEUE_DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .wdata (bus.in_instruction),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign opcode    = head[6:0];
    assign rs1       = head[19:15];
    assign rs2       = head[24:20];
    assign check_rs1 = uses_rs1(opcode);
    assign check_rs2 = uses_rs2(opcode);

    assign stage_wen[STAGE_ID]   = id_wen;
    assign stage_wen[STAGE_EXE]  = exe_wen;
    assign stage_wen[STAGE_MEM]  = mem_wen;
    assign stage_wen[STAGE_WB]   = wb_wen;
    assign stage_dest[STAGE_ID]  = id_dest;
    assign stage_dest[STAGE_EXE] = exe_dest;
    assign stage_dest[STAGE_MEM] = mem_dest;
    assign stage_dest[STAGE_WB]  = wb_dest;

    // x0 is never a real dependency, so a zero destination cannot stall.
    always_comb begin
        stage_hazard = '0;
        for (int s = 0; s < NUM_STAGES; s++) begin
            stage_hazard[s] = HAZARD_MASK[s] && stage_wen[s] && (stage_dest[s] != 5'd0) &&
                              ((check_rs1 && (stage_dest[s] == rs1)) ||
                               (check_rs2 && (stage_dest[s] == rs2)));
        end
    end

    assign hazard = |stage_hazard;

    // in_ready depends on occupancy only, never on out_ready.
    assign bus.in_ready        = !full;
    assign bus.out_valid       = !empty && !hazard;
    assign bus.out_instruction = head;
    assign out_valid_unused_mirror = bus.out_valid;

    assign push = bus.in_valid && !full;
    assign pop  = bus.out_valid && bus.out_ready;

    always_comb begin
        stall_d = stall_q;
        if (!empty && hazard && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_count = stall_q;

    logic unused_bits;
    assign unused_bits = ^{report, head[DATA_WIDTH-1:25], head[14:7]};

endmodule

// File: tb/tb_dispatch_scoreboard.sv
module tb_dispatch_scoreboard;

    logic        clock = 1'b0;
    logic        reset;
    logic        report;
    logic        flush;
    logic [4:0]  id_dest, exe_dest, mem_dest, wb_dest;
    logic        id_wen, exe_wen, mem_wen, wb_wen;
    logic [3:0]  count, count_m;
    logic [31:0] stall_count, stall_m;
    logic        ov_mirror, ov_mirror_m;

    int          vectors = 0;
    int          miscompares = 0;
    int          exp_stall = 0;
    logic [31:0] exp_q [$];

    always #5 clock = ~clock;

    dispatch_scoreboard_if #(.DATA_WIDTH(32)) bus ();
    dispatch_scoreboard_if #(.DATA_WIDTH(32)) bus_m ();

    dispatch_scoreboard dut (
        .clock                   (clock),
        .reset                   (reset),
        .report                  (report),
        .flush                   (flush),
        .bus                     (bus),
        .id_dest                 (id_dest),
        .exe_dest                (exe_dest),
        .mem_dest                (mem_dest),
        .wb_dest                 (wb_dest),
        .id_wen                  (id_wen),
        .exe_wen                 (exe_wen),
        .mem_wen                 (mem_wen),
        .wb_wen                  (wb_wen),
        .out_valid_unused_mirror (ov_mirror),
        .count                   (count),
        .stall_count             (stall_count)
    );

    // Same stimulus, EXE stage excluded from hazard checks.
    dispatch_scoreboard #(.HAZARD_MASK(4'b1101)) dut_m (
        .clock                   (clock),
        .reset                   (reset),
        .report                  (report),
        .flush                   (flush),
        .bus                     (bus_m),
        .id_dest                 (id_dest),
        .exe_dest                (exe_dest),
        .mem_dest                (mem_dest),
        .wb_dest                 (wb_dest),
        .id_wen                  (id_wen),
        .exe_wen                 (exe_wen),
        .mem_wen                 (mem_wen),
        .wb_wen                  (wb_wen),
        .out_valid_unused_mirror (ov_mirror_m),
        .count                   (count_m),
        .stall_count             (stall_m)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [31:0] instr);
        bus.in_valid         = v;
        bus.in_instruction   = instr;
        bus_m.in_valid       = v;
        bus_m.in_instruction = instr;
    endtask

    task automatic enq(input logic [31:0] instr);
        set_in(1'b1, instr);
        exp_q.push_back(instr);
        tick();
        set_in(1'b0, 32'h0);
    endtask

    // Head instruction against one stage hazard setup; out_ready held high.
    task automatic op_case(input string nm, input logic [31:0] instr,
                           input logic [4:0] idd, input logic idw,
                           input logic [4:0] md, input logic mw, input logic expv);
        enq(instr);
        id_dest = idd; id_wen = idw; mem_dest = md; mem_wen = mw;
        @(negedge clock);
        chk(nm, {31'd0, bus.out_valid}, {31'd0, expv});
        tick();
        if (!expv) begin
            exp_stall++;
            id_wen = 1'b0; mem_wen = 1'b0;
            @(negedge clock);
            chk({nm, "_release"}, {31'd0, bus.out_valid}, 32'd1);
            tick();
        end
        id_wen = 1'b0; mem_wen = 1'b0;
        @(negedge clock);
        chk({nm, "_stall"}, stall_count, exp_stall);
    endtask

    // Scoreboard monitor: every accepted dispatch must match the next queued entry.
    always @(negedge clock) begin
        logic [31:0] e;
        if (!reset && !flush && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL dispatch_order: got %h, expected no dispatch", bus.out_instruction);
            end else begin
                e = exp_q.pop_front();
                if (bus.out_instruction !== e) begin
                    miscompares++;
                    $display("FAIL dispatch_order: got %h, expected %h", bus.out_instruction, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; report = 1'b0; flush = 1'b0;
        id_dest = 5'd0; exe_dest = 5'd0; mem_dest = 5'd0; wb_dest = 5'd0;
        id_wen = 1'b0; exe_wen = 1'b0; mem_wen = 1'b0; wb_wen = 1'b0;
        set_in(1'b0, 32'h0);
        bus.out_ready = 1'b0; bus_m.out_ready = 1'b0;

        tick(); tick();
        @(negedge clock);
        chk("rst_count", count, 0);
        chk("rst_stall", stall_count, 0);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 1);
        tick();
        reset = 1'b0;

        // Fill and drain
        enq(32'h1000_0013);
        @(negedge clock);
        chk("latency_valid", {31'd0, bus.out_valid}, 1);
        chk("latency_count", count, 1);
        tick();
        for (int i = 1; i < 8; i++) enq(32'h1000_0013 + (i << 7));
        @(negedge clock);
        chk("fill_count", count, 8);
        chk("fill_in_ready", {31'd0, bus.in_ready}, 0);
        tick();
        bus.out_ready = 1'b1;
        repeat (8) tick();
        bus.out_ready = 1'b0;
        @(negedge clock);
        chk("drain_count", count, 0);
        chk("drain_all", exp_q.size(), 0);
        tick();

        // RAW hazard on EXE, masked instance ignores EXE
        bus.out_ready = 1'b1;
        enq(32'h0020_81B3);
        exe_wen = 1'b1; exe_dest = 5'd1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk("raw_valid", {31'd0, bus.out_valid}, 0);
            chk("raw_stall", stall_count, exp_stall);
            chk("mask_valid", {31'd0, bus_m.out_valid}, 1);
            tick();
            exp_stall++;
        end
        wb_wen = 1'b1; wb_dest = 5'd0;
        @(negedge clock);
        chk("raw_valid_wb0", {31'd0, bus.out_valid}, 0);
        chk("mask_valid_wb0", {31'd0, bus_m.out_valid}, 1);
        chk("raw_stall3", stall_count, exp_stall);
        tick();
        exp_stall++;
        exe_wen = 1'b0;
        @(negedge clock);
        chk("raw_release", {31'd0, bus.out_valid}, 1);
        chk("raw_stall4", stall_count, exp_stall);
        chk("mask_stall", stall_m, 0);
        tick();
        wb_wen = 1'b0;
        @(negedge clock);
        chk("raw_count", count, 0);
        tick();

        // Opcode filtering of source fields
        op_case("lui_x0",     32'h0000_52B7, 5'd0,  1'b1, 5'd0, 1'b0, 1'b1);
        op_case("lui_rs1f",   32'h000F_A2B7, 5'd31, 1'b1, 5'd0, 1'b0, 1'b1);
        op_case("addi_rs1",   32'h000F_8313, 5'd31, 1'b1, 5'd0, 1'b0, 1'b0);
        op_case("sw_rs2",     32'h0020_A023, 5'd0,  1'b0, 5'd2, 1'b1, 1'b0);
        op_case("addi_rs2f",  32'h002F_8313, 5'd0,  1'b0, 5'd2, 1'b1, 1'b1);
        op_case("jal_rs1f",   32'h000F_80EF, 5'd31, 1'b1, 5'd0, 1'b0, 1'b1);
        op_case("beq_rs2",    32'h0020_8063, 5'd0,  1'b0, 5'd2, 1'b1, 1'b0);
        tick();

        // Full queue with simultaneous handshakes, then flush
        bus.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) enq(32'h2000_0013 + (i << 7));
        @(negedge clock);
        chk("full_count", count, 8);
        chk("full_in_ready", {31'd0, bus.in_ready}, 0);
        tick();
        set_in(1'b1, 32'hDEAD_0013);
        bus.out_ready = 1'b1;
        tick();
        set_in(1'b0, 32'h0);
        bus.out_ready = 1'b0;
        @(negedge clock);
        chk("full_enq_refused", count, 7);
        tick();
        set_in(1'b1, 32'h3000_0013);
        exp_q.push_back(32'h3000_0013);
        bus.out_ready = 1'b1;
        tick();
        set_in(1'b0, 32'h0);
        bus.out_ready = 1'b0;
        @(negedge clock);
        chk("simul_count", count, 7);
        tick();
        flush = 1'b1;
        set_in(1'b1, 32'h4000_0013);
        bus.out_ready = 1'b1;
        tick();
        flush = 1'b0;
        set_in(1'b0, 32'h0);
        bus.out_ready = 1'b0;
        exp_q.delete();
        @(negedge clock);
        chk("flush_count", count, 0);
        chk("flush_out_valid", {31'd0, bus.out_valid}, 0);
        chk("flush_in_ready", {31'd0, bus.in_ready}, 1);
        chk("flush_keeps_stall", stall_count, exp_stall);
        chk("flush_count_m", count_m, 0);
        tick();

        // Reset mid-operation
        for (int i = 0; i < 5; i++) enq(32'h5000_0013 + (i << 7));
        @(negedge clock);
        chk("pre_rst_count", count, 5);
        chk("pre_rst_stall", stall_count, exp_stall);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        exp_stall = 0;
        @(negedge clock);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_stall", stall_count, 0);
        chk("mid_rst_out_valid", {31'd0, bus.out_valid}, 0);
        chk("mid_rst_in_ready", {31'd0, bus.in_ready}, 1);
        tick();

        // Queue still usable after reset
        bus.out_ready = 1'b1;
        enq(32'h6000_0013);
        @(negedge clock);
        chk("post_rst_valid", {31'd0, bus.out_valid}, 1);
        tick();
        bus.out_ready = 1'b0;
        @(negedge clock);
        chk("post_rst_count", count, 0);
        chk("sb_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
